// File: rtl/regfile_pkg.sv
// Shared definitions for the general-purpose register file: default sizes, named registers, bus-select helper.
// Latency: none (declarations and a pure function only).
// Backpressure: none.
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NREG  = 4;
  localparam int MAX_NREG      = 16;

  // Named register indices used by the control unit (legacy A/B/X/Q bank).
  localparam int REG_A = 0;
  localparam int REG_B = 1;
  localparam int REG_X = 2;
  localparam int REG_Q = 3;

  // Winner of the bus arbitration: vld low means nobody drives.
  typedef struct packed {
    logic       vld;
    logic [3:0] idx;
  } busSel_t;

  // Index of the lowest set bit of act; the downward scan lets the lowest index overwrite higher ones.
  function automatic busSel_t lowestActive(input logic [MAX_NREG-1:0] act);
    busSel_t sel;
    sel = '0;
    for (int i = MAX_NREG - 1; i >= 0; i--) begin
      if (act[i]) begin
        sel.vld = 1'b1;
        sel.idx = 4'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_bus_gpr_cell.sv
// One WIDTH-bit general-purpose register with load > inc/dec > hold priority and a zero flag.
// Latency: 1 cycle from load/inc/dec to value; zero is combinational from the stored value.
// Backpressure: none; every strobe is acted on at the next clk rise.
module gpr_cell #(
  parameter int WIDTH = regfile_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetBar,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] busIn,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  // Register update: load wins, inc and dec together cancel, otherwise count.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      value <= '0;
    end else if (load) begin
      value <= busIn;
    end else if (inc && !dec) begin
      value <= value + WIDTH'(1);
    end else if (dec && !inc) begin
      value <= value - WIDTH'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/regfile_bus.sv
// Parametrised register file on a shared tri-state bus, with optional contention detector (REGFILE_CONFLICT_EN).
// Latency: bus drive combinational; register updates and conflict flag 1 cycle.
// Backpressure: none; lowest-index enabled assert wins the bus, extra asserts are only flagged.
module regfile_bus
  import regfile_pkg::*;
#(
  parameter int              WIDTH       = DEFAULT_WIDTH,
  parameter int              NREG        = DEFAULT_NREG,
  parameter logic [NREG-1:0] ASSERT_MASK = 4'b0101
) (
  input  logic                 clk,
  input  logic                 resetBar,
  input  logic [NREG-1:0]      load,
  input  logic [NREG-1:0]      assertBar,
  input  logic [NREG-1:0]      inc,
  input  logic [NREG-1:0]      dec,
  inout  wire  [WIDTH-1:0]     dbus,
  output logic [NREG*WIDTH-1:0] regs,
  output logic [NREG-1:0]      zero,
  output logic                 conflict,
  input  logic                 clearConflict
);

  logic [WIDTH-1:0] cellVal [NREG];
  logic [NREG-1:0]  activeAssert;
  busSel_t          busSel;
  logic [WIDTH-1:0] busValue;
  logic             busDrive;

  // Registers that want the bus and are allowed to have it.
  assign activeAssert = ~assertBar & ASSERT_MASK;
  assign busSel       = lowestActive(MAX_NREG'(activeAssert));

  // Select the winning register's value; a compare loop keeps the index width independent of NREG.
  always_comb begin
    busValue = '0;
    for (int i = 0; i < NREG; i++) begin
      if (busSel.idx == 4'(i)) busValue = cellVal[i];
    end
  end

  // The only tri-state driver in the block; released while reset is asserted.
  assign busDrive = busSel.vld & resetBar;
  assign dbus     = busDrive ? busValue : {WIDTH{1'bz}};

  genvar g;
  generate
    for (g = 0; g < NREG; g++) begin : gCell
      gpr_cell #(.WIDTH(WIDTH)) uCell (
        .clk      (clk),
        .resetBar (resetBar),
        .load     (load[g]),
        .inc      (inc[g]),
        .dec      (dec[g]),
        .busIn    (dbus),
        .value    (cellVal[g]),
        .zero     (zero[g])
      );
      assign regs[g*WIDTH +: WIDTH] = cellVal[g];
    end
  endgenerate

`ifdef REGFILE_CONFLICT_EN
  logic multiAssert;

  // Two or more enabled asserts: clearing the lowest set bit leaves something behind.
  assign multiAssert = |(activeAssert & (activeAssert - NREG'(1)));

  // Sticky contention flag; a fresh conflict overrides a clear in the same cycle.
  always_ff @(posedge clk or negedge resetBar) begin
    if (!resetBar) begin
      conflict <= 1'b0;
    end else if (multiAssert) begin
      conflict <= 1'b1;
    end else if (clearConflict) begin
      conflict <= 1'b0;
    end
  end
`else
  logic unusedClear;
  assign unusedClear = clearConflict;
  assign conflict    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_bus.sv
module tb_regfile_bus;

`ifdef REGFILE_CONFLICT_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetBar;
  logic [3:0]  load, assertBar, inc, dec;
  logic        clearConflict;
  logic [7:0]  extVal;
  logic        extEn;
  wire  [7:0]  dbus;
  logic [31:0] regs;
  logic [3:0]  zero;
  logic        conflict;

  int passCnt = 0;
  int totalCnt = 0;

  assign dbus = extEn ? extVal : 8'hzz;

  regfile_bus #(.WIDTH(8), .NREG(4), .ASSERT_MASK(4'b0101)) dut (
    .clk           (clk),
    .resetBar      (resetBar),
    .load          (load),
    .assertBar     (assertBar),
    .inc           (inc),
    .dec           (dec),
    .dbus          (dbus),
    .regs          (regs),
    .zero          (zero),
    .conflict      (conflict),
    .clearConflict (clearConflict)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passCnt, totalCnt);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    load = 4'b0000; assertBar = 4'b1111; inc = 4'b0000; dec = 4'b0000;
    clearConflict = 1'b0; extEn = 1'b0; extVal = 8'h00;
  endtask

  // Load register(s) from an externally driven bus value.
  task automatic extLoad(input logic [3:0] mask, input logic [7:0] v);
    extEn = 1'b1; extVal = v; load = mask;
    tick;
    idle;
  endtask

  task automatic test_reset;
    idle;
    resetBar = 1'b0;
    #3;
    totalCnt++;
    if (regs !== 32'h0) $display("FAIL reset_regs: got %h want %h", regs, 32'h0); else passCnt++;
    totalCnt++;
    if (zero !== 4'b1111) $display("FAIL reset_zero: got %b want %b", zero, 4'b1111); else passCnt++;
    totalCnt++;
    if (conflict !== 1'b0) $display("FAIL reset_conflict: got %b want 0", conflict); else passCnt++;
    tick;
    resetBar = 1'b1;
  endtask

  task automatic test_broadcast;
    extLoad(4'b1111, 8'h5A);
    totalCnt++;
    if (regs !== 32'h5A5A5A5A) $display("FAIL broadcast_regs: got %h want %h", regs, 32'h5A5A5A5A); else passCnt++;
    totalCnt++;
    if (zero !== 4'b0000) $display("FAIL broadcast_zero: got %b want %b", zero, 4'b0000); else passCnt++;
  endtask

  task automatic test_transfer;
    extLoad(4'b0001, 8'h12);
    assertBar = 4'b1110; load = 4'b0010;
    #1;
    totalCnt++;
    if (dbus !== 8'h12) $display("FAIL transfer_dbus: got %h want %h", dbus, 8'h12); else passCnt++;
    tick;
    idle;
    totalCnt++;
    if (regs !== 32'h5A5A1212) $display("FAIL transfer_regs: got %h want %h", regs, 32'h5A5A1212); else passCnt++;
    // Register 0 loading itself while driving keeps its value.
    assertBar = 4'b1110; load = 4'b0001;
    tick;
    idle;
    totalCnt++;
    if (regs[7:0] !== 8'h12) $display("FAIL self_load: got %h want %h", regs[7:0], 8'h12); else passCnt++;
  endtask

  task automatic test_incdec;
    extLoad(4'b0100, 8'hFF);
    inc = 4'b0100;
    tick;
    idle;
    totalCnt++;
    if (regs[23:16] !== 8'h00) $display("FAIL inc_wrap: got %h want %h", regs[23:16], 8'h00); else passCnt++;
    totalCnt++;
    if (zero !== 4'b0100) $display("FAIL inc_wrap_zero: got %b want %b", zero, 4'b0100); else passCnt++;
    dec = 4'b0100;
    tick;
    idle;
    totalCnt++;
    if (regs[23:16] !== 8'hFF) $display("FAIL dec_wrap: got %h want %h", regs[23:16], 8'hFF); else passCnt++;
    inc = 4'b0100; dec = 4'b0100;
    tick;
    idle;
    totalCnt++;
    if (regs[23:16] !== 8'hFF) $display("FAIL incdec_hold: got %h want %h", regs[23:16], 8'hFF); else passCnt++;
    // Plain increment and decrement on register 3 (5A).
    inc = 4'b1000;
    tick;
    idle;
    totalCnt++;
    if (regs[31:24] !== 8'h5B) $display("FAIL inc_plain: got %h want %h", regs[31:24], 8'h5B); else passCnt++;
    dec = 4'b1000;
    tick; tick;
    idle;
    totalCnt++;
    if (regs[31:24] !== 8'h59) $display("FAIL dec_plain: got %h want %h", regs[31:24], 8'h59); else passCnt++;
  endtask

  task automatic test_load_priority;
    extLoad(4'b0100, 8'h07);
    extEn = 1'b1; extVal = 8'h30; load = 4'b0100; inc = 4'b0100;
    tick;
    idle;
    totalCnt++;
    if (regs[23:16] !== 8'h30) $display("FAIL load_over_inc: got %h want %h", regs[23:16], 8'h30); else passCnt++;
  endtask

  task automatic test_conflict;
    // reg0=12, reg2=30: both enabled asserts; lowest index wins.
    assertBar = 4'b1010;
    #1;
    totalCnt++;
    if (dbus !== 8'h12) $display("FAIL conflict_dbus: got %h want %h", dbus, 8'h12); else passCnt++;
    tick;
    totalCnt++;
    if (conflict !== CONF_EN) $display("FAIL conflict_set: got %b want %b", conflict, CONF_EN); else passCnt++;
    clearConflict = 1'b1;
    tick;
    totalCnt++;
    if (conflict !== CONF_EN) $display("FAIL conflict_set_wins: got %b want %b", conflict, CONF_EN); else passCnt++;
    assertBar = 4'b1111;
    tick;
    idle;
    totalCnt++;
    if (conflict !== 1'b0) $display("FAIL conflict_clear: got %b want 0", conflict); else passCnt++;
    // Register 2 alone drives.
    assertBar = 4'b1011;
    #1;
    totalCnt++;
    if (dbus !== 8'h30) $display("FAIL reg2_drive: got %h want %h", dbus, 8'h30); else passCnt++;
    idle;
  endtask

  task automatic test_mask;
    // Registers 1 and 3 are masked: the external C0 must reach register 3 undisturbed.
    assertBar = 4'b0101; extEn = 1'b1; extVal = 8'hC0; load = 4'b1000;
    tick;
    idle;
    totalCnt++;
    if (regs[31:24] !== 8'hC0) $display("FAIL mask_no_drive: got %h want %h", regs[31:24], 8'hC0); else passCnt++;
    totalCnt++;
    if (conflict !== 1'b0) $display("FAIL mask_no_conflict: got %b want 0", conflict); else passCnt++;
  endtask

  task automatic test_reset_mid;
    assertBar = 4'b1010;
    tick;
    assertBar = 4'b1110; inc = 4'b0001; extEn = 1'b1; extVal = 8'hA5;
    #2;
    resetBar = 1'b0;
    #1;
    totalCnt++;
    if (regs !== 32'h0) $display("FAIL midreset_regs: got %h want %h", regs, 32'h0); else passCnt++;
    totalCnt++;
    if (conflict !== 1'b0) $display("FAIL midreset_conflict: got %b want 0", conflict); else passCnt++;
    totalCnt++;
    if (dbus !== 8'hA5) $display("FAIL midreset_dbus: got %h want %h", dbus, 8'hA5); else passCnt++;
    tick;
    extEn = 1'b0;
    resetBar = 1'b1;
    tick;
    idle;
    totalCnt++;
    if (regs !== 32'h00000001) $display("FAIL release_inc: got %h want %h", regs, 32'h00000001); else passCnt++;
  endtask

  initial begin
    test_reset;
    test_broadcast;
    test_transfer;
    test_incdec;
    test_load_priority;
    test_conflict;
    test_mask;
    test_reset_mid;
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
